axil_regbank: RTL and testbench

- Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit PS-PL test register slave.
- Adds configurable width and depth, read-only status words fed from PL logic, byte strobes, SLVERR decoding and per-register write pulses.
- Sits behind the PS AXI interconnect and exposes control registers to acoustic-camera PL datapath blocks.

---
 rtl/axil_regbank.sv | 257 +++++++++++++++++++++++++
 tb/tb_axil_regbank.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave with RW control words, read-only status words and write pulses.
// Optional IRQ block (sticky IRQ_STAT, IRQ_EN, irq output) enabled by defining AXIL_REGBANK_IRQ_EN.
module axil_regbank #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 6,
  parameter int                NUM_REGS   = 4,
  parameter int                NUM_STATUS = 2,
  parameter logic [DATA_W-1:0] RESET_VAL  = {DATA_W{1'b0}}
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_STATUS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]          wr_pulse
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  input  logic [DATA_W-1:0]            irq_src,
  output logic                         irq
`endif
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam int IRQ_STAT_IDX = NUM_REGS + NUM_STATUS;
  localparam int IRQ_EN_IDX   = NUM_REGS + NUM_STATUS + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;

  function automatic int word_idx(input logic [ADDR_W-1:0] a);
    return {{(32-IDX_W){1'b0}}, a[ADDR_W-1:ADDR_LSB]};
  endfunction

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < STRB_W; b++) begin
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  wstate_e             wstate_q, wstate_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   reg_d [NUM_REGS];
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s, rd_ok_s;
  int                  widx_s, ridx_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                unused_ok_s;

  assign aw_hs_s     = S_AXI_AWVALID & awready_q;
  assign w_hs_s      = S_AXI_WVALID & wready_q;
  assign ar_hs_s     = S_AXI_ARVALID & arready_q;
  assign ridx_s      = word_idx(S_AXI_ARADDR);
  assign unused_ok_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

`ifdef AXIL_REGBANK_IRQ_EN
  logic [DATA_W-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
  logic              irq_q;
`endif

  // Write channel: latch AW/W independently, commit once both are present, hold B until BREADY
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q | aw_hs_s;
    w_held_d  = w_held_q | w_hs_s;
    awaddr_d  = aw_hs_s ? S_AXI_AWADDR : awaddr_q;
    wdata_d   = w_hs_s ? S_AXI_WDATA : wdata_q;
    wstrb_d   = w_hs_s ? S_AXI_WSTRB : wstrb_q;
    commit_s  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_held_d && w_held_d) begin
          commit_s = 1'b1;
          wstate_d = W_RESP;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = (wstate_d == W_IDLE) && !w_held_d;
    bvalid_d  = (wstate_d == W_RESP);
  end

  // Write decode: byte-merge into the addressed RW word, pulse it, pick the response code
  always_comb begin
    widx_s = word_idx(awaddr_d);
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k]      = (commit_s && widx_s == k) ? strb_merge(reg_q[k], wdata_d, wstrb_d) : reg_q[k];
      wr_pulse_d[k] = commit_s && (widx_s == k);
    end
`ifdef AXIL_REGBANK_IRQ_EN
    wr_ok_s = (widx_s < NUM_REGS) || (widx_s == IRQ_STAT_IDX) || (widx_s == IRQ_EN_IDX);
`else
    wr_ok_s = (widx_s < NUM_REGS);
`endif
    bresp_d = commit_s ? (wr_ok_s ? RESP_OKAY : RESP_SLVERR) : bresp_q;
  end

  // Read mux: RW words, then status words, then optional IRQ words; anything else is SLVERR
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    rd_ok_s   = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_word_s = rd_word_s | ((ridx_s == k) ? reg_q[k] : {DATA_W{1'b0}});
      rd_ok_s   = rd_ok_s | (ridx_s == k);
    end
    for (int k = 0; k < NUM_STATUS; k++) begin
      rd_word_s = rd_word_s | ((ridx_s == NUM_REGS + k) ? reg_in[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
      rd_ok_s   = rd_ok_s | (ridx_s == NUM_REGS + k);
    end
`ifdef AXIL_REGBANK_IRQ_EN
    rd_word_s = rd_word_s | ((ridx_s == IRQ_STAT_IDX) ? irq_stat_q : {DATA_W{1'b0}})
                          | ((ridx_s == IRQ_EN_IDX) ? irq_en_q : {DATA_W{1'b0}});
    rd_ok_s   = rd_ok_s | (ridx_s == IRQ_STAT_IDX) | (ridx_s == IRQ_EN_IDX);
`endif
    rvalid_d  = ar_hs_s | (rvalid_q & ~S_AXI_RREADY);
    arready_d = ~rvalid_d;
    rdata_d   = ar_hs_s ? rd_word_s : rdata_q;
    rresp_d   = ar_hs_s ? (rd_ok_s ? RESP_OKAY : RESP_SLVERR) : rresp_q;
  end

  // Write-channel and register-file state
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q   <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= {NUM_REGS{1'b0}};
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= RESET_VAL;
    end else begin
      wstate_q   <= wstate_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= reg_d[k];
    end
  end

  // Read-channel state; the read samples pre-commit register values
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
      rresp_q   <= 2'b00;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef AXIL_REGBANK_IRQ_EN
  // Sticky status with write-1-to-clear; a new source bit beats a simultaneous clear
  always_comb begin
    irq_stat_d = (irq_stat_q
                  & ~((commit_s && widx_s == IRQ_STAT_IDX)
                      ? strb_merge({DATA_W{1'b0}}, wdata_d, wstrb_d) : {DATA_W{1'b0}}))
                 | irq_src;
    irq_en_d   = (commit_s && widx_s == IRQ_EN_IDX) ? strb_merge(irq_en_q, wdata_d, wstrb_d) : irq_en_q;
  end

  // Interrupt registers and output
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_stat_q <= {DATA_W{1'b0}};
      irq_en_q   <= {DATA_W{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign irq = irq_q;
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[k*DATA_W +: DATA_W] = reg_q[k];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axil_regbank.sv
// Scoreboard bench for axil_regbank: stimulus pushes expected B/R responses, a monitor pops them.
// IRQ checks are compiled in when AXIL_REGBANK_IRQ_EN is defined.
module tb_axil_regbank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         ACLK, ARESET;
  logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [127:0] reg_out;
  logic [63:0]  reg_in;
  logic [3:0]   wr_pulse;
`ifdef AXIL_REGBANK_IRQ_EN
  logic [31:0]  irq_src;
  logic         irq;
`endif

  axil_regbank dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
`ifdef AXIL_REGBANK_IRQ_EN
    , .irq_src(irq_src), .irq(irq)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_cnt[4] = '{0, 0, 0, 0};

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got BVALID with resp %0h, expected no response", S_AXI_BRESP);
        end else begin
          e = bq.pop_front();
          check({e.name, "_bresp"}, {126'd0, S_AXI_BRESP}, {126'd0, e.resp});
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL r_unexpected: got RVALID with data %0h, expected no response", S_AXI_RDATA);
        end else begin
          e = rq.pop_front();
          check({e.name, "_rdata"}, {96'd0, S_AXI_RDATA}, {96'd0, e.data});
          check({e.name, "_rresp"}, {126'd0, S_AXI_RRESP}, {126'd0, e.resp});
        end
      end
    end
  endtask

  task automatic pulse_counter();
    forever begin
      @(negedge ACLK);
      for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(wr_pulse[k]);
    end
  endtask

  function automatic int pulse_sum();
    return pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
  endfunction

  // Starts and ends #1 after a rising edge.
  task automatic axi_write(input string nm, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    exp_t e;
    bit   aw_p, w_p, aw_f, w_f, done;
    int   n;
    e.name = nm; e.data = 32'h0; e.resp = er;
    bq.push_back(e);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0;
    while ((aw_p || w_p) && n < 20) begin
      @(negedge ACLK);
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_f) begin S_AXI_AWVALID = 1'b0; aw_p = 1'b0; end
      if (w_f) begin S_AXI_WVALID = 1'b0; w_p = 1'b0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge ACLK);
      done = S_AXI_BVALID;
      @(posedge ACLK); #1;
      n++;
    end
    check({nm, "_b_handshake_in_time"}, {127'd0, done}, {127'd0, 1'b1});
  endtask

  task automatic axi_read(input string nm, input logic [5:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
    exp_t e;
    bit   ar_p, done;
    int   n;
    e.name = nm; e.data = ed; e.resp = er;
    rq.push_back(e);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    ar_p = 1'b1; n = 0;
    while (ar_p && n < 20) begin
      @(negedge ACLK);
      ar_p = !S_AXI_ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      @(negedge ACLK);
      done = S_AXI_RVALID;
      @(posedge ACLK); #1;
      n++;
    end
    check({nm, "_r_handshake_in_time"}, {127'd0, done}, {127'd0, 1'b1});
  endtask

  initial begin
    exp_t e;
    int   n, psum;
    ARESET = 1'b1;
    S_AXI_AWADDR = 6'h0; S_AXI_AWPROT = 3'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 6'h0; S_AXI_ARPROT = 3'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    reg_in = {32'h12345678, 32'hDEADBEEF};
`ifdef AXIL_REGBANK_IRQ_EN
    irq_src = 32'h0;
`endif
    fork
      monitor();
      pulse_counter();
    join_none

    // Reset state
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_ready_valid", {123'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
    check("rst_resp_data", {92'd0, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 128'd0);
    check("rst_wr_pulse", {124'd0, wr_pulse}, 128'd0);
    check("rst_reg_out", reg_out, 128'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("ready_after_release", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, {125'd0, 3'b111});
    @(posedge ACLK); #1;

    // Basic write / read-back of all RW words
    axi_write("wr0", 6'h00, 32'h1, 4'hF, OKAY);
    axi_write("wr1", 6'h04, 32'h2, 4'hF, OKAY);
    axi_write("wr2", 6'h08, 32'h3, 4'hF, OKAY);
    axi_write("wr3", 6'h0C, 32'h4, 4'hF, OKAY);
    axi_read("rd0", 6'h00, 32'h1, OKAY);
    axi_read("rd1", 6'h04, 32'h2, OKAY);
    axi_read("rd2", 6'h08, 32'h3, OKAY);
    axi_read("rd3", 6'h0C, 32'h4, OKAY);
    check("arready_after_r", {127'd0, S_AXI_ARREADY}, {127'd0, 1'b1});
    for (int k = 0; k < 4; k++) check($sformatf("pulse_once_%0d", k), 128'(pulse_cnt[k]), 128'd1);
    check("reg_out_basic", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

    // Byte strobes
    axi_write("wr_full", 6'h00, 32'hAABBCCDD, 4'hF, OKAY);
    axi_write("wr_strb", 6'h00, 32'h11223344, 4'b0101, OKAY);
    axi_read("rd_strb", 6'h00, 32'hAA22CC44, OKAY);
    axi_write("wr_nostrb", 6'h04, 32'hFFFFFFFF, 4'b0000, OKAY);
    check("pulse_zero_strb", 128'(pulse_cnt[1]), 128'd2);
    axi_read("rd_nostrb", 6'h04, 32'h2, OKAY);

    // Status words, SLVERR decode, ignored LSBs
    axi_read("rd_stat0", 6'h10, 32'hDEADBEEF, OKAY);
    axi_read("rd_stat1", 6'h14, 32'h12345678, OKAY);
    psum = pulse_sum();
    axi_write("wr_stat0", 6'h10, 32'h0, 4'hF, SLVERR);
    axi_write("wr_oor", 6'h3C, 32'h5A5A5A5A, 4'hF, SLVERR);
    check("no_pulse_on_slverr", 128'(pulse_sum()), 128'(psum));
    check("reg_out_after_slverr", reg_out, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    axi_read("rd_stat0_again", 6'h10, 32'hDEADBEEF, OKAY);
    axi_read("rd_oor", 6'h3C, 32'h0, SLVERR);
    axi_read("rd_unaligned", 6'h0B, 32'h3, OKAY);

    // W three cycles ahead of AW, BREADY held low
    e.name = "late_aw"; e.data = 32'h0; e.resp = OKAY;
    bq.push_back(e);
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'h0000CAFE; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    check("wready_low_while_held", {127'd0, S_AXI_WREADY}, 128'd0);
    repeat (2) begin @(posedge ACLK); #1; end
    check("no_b_before_aw", {127'd0, S_AXI_BVALID}, 128'd0);
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    check("b_latency", {127'd0, S_AXI_BVALID}, {127'd0, 1'b1});
    repeat (5) begin
      @(negedge ACLK);
      check("b_hold", {123'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, {123'd0, 5'b1_00_00});
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    check("b_done_ready", {125'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, {125'd0, 3'b011});
    axi_read("rd_late_aw", 6'h08, 32'h0000CAFE, OKAY);

    // Read and write commit to the same word in one cycle
    e.name = "rw_same_wr"; e.data = 32'h0; e.resp = OKAY;
    bq.push_back(e);
    e.name = "rw_same_rd"; e.data = 32'h4; e.resp = OKAY;
    rq.push_back(e);
    S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (3) begin @(posedge ACLK); #1; end
    axi_read("rd_after_same", 6'h0C, 32'h99, OKAY);

    // Reset with B and R both outstanding
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("pre_rst_valids", {126'd0, S_AXI_BVALID, S_AXI_RVALID}, {126'd0, 2'b11});
    check("pre_rst_reg1", {96'd0, reg_out[63:32]}, {96'd0, 32'h55});
    #2;
    ARESET = 1'b1;
    #1;
    check("rst_mid_valids", {126'd0, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
    check("rst_mid_reg_out", reg_out, 128'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      check("no_stale_resp", {126'd0, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
    end
    @(posedge ACLK); #1;
    axi_read("rd_post_rst", 6'h00, 32'h0, OKAY);

`ifdef AXIL_REGBANK_IRQ_EN
    // Interrupt words
    irq_src = 32'h8;
    @(posedge ACLK); #1;
    irq_src = 32'h0;
    axi_write("wr_irq_en", 6'h1C, 32'h8, 4'hF, OKAY);
    @(posedge ACLK); #1;
    check("irq_set", {127'd0, irq}, {127'd0, 1'b1});
    axi_read("rd_irq_stat", 6'h18, 32'h8, OKAY);
    axi_read("rd_irq_en", 6'h1C, 32'h8, OKAY);
    axi_write("wr_irq_clr", 6'h18, 32'h8, 4'hF, OKAY);
    @(negedge ACLK);
    check("irq_cleared", {127'd0, irq}, 128'd0);
    @(posedge ACLK); #1;
    irq_src = 32'h8;
    axi_write("wr_irq_clr_race", 6'h18, 32'h8, 4'hF, OKAY);
    irq_src = 32'h0;
    axi_read("rd_irq_stat_sticky", 6'h18, 32'h8, OKAY);
    check("irq_still_set", {127'd0, irq}, {127'd0, 1'b1});
    axi_read("rd_irq_oor", 6'h20, 32'h0, SLVERR);
`else
    // No interrupt words: their indices are out of range
    axi_read("rd_idx6_oor", 6'h18, 32'h0, SLVERR);
    axi_read("rd_idx7_oor", 6'h1C, 32'h0, SLVERR);
    axi_write("wr_idx7_oor", 6'h1C, 32'h8, 4'hF, SLVERR);
`endif

    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    check("scoreboard_drained", 128'(bq.size() + rq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
